// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if
// Description : SPI pin bundle between an SPI master and an SPI target.
//               master modport drives SCLK/CS_N/MOSI and observes MISO/OE;
//               slave modport is the mirror image.
//   spi_clk     : serial clock from the master
//   spi_cs_n    : chip select, active low
//   spi_mosi    : master-to-target data
//   spi_miso    : target-to-master data (0 when not driving)
//   spi_miso_oe : target tristate enable for spi_miso
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if;
    logic spi_clk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : Oversampling SPI target, all four CPOL/CPHA modes, MSB first,
//               fixed word length, back-to-back words inside one CS window.
//               TX words come from a one-entry valid/ready buffer; RX words
//               are reported with a one-cycle rx_valid pulse.
// Ports       :
//   clk, rst           : system clock, asynchronous active-high reset
//   cpol, cpha         : SPI mode (static while spi_cs_n is high)
//   tx_data/valid/ready: one-entry TX buffer load handshake
//   rx_data, rx_valid  : last complete received word and its update pulse
//   busy               : high while a chip-select window is active
//   tx_underrun        : pulse, a word started with the TX buffer empty
//   frame_error        : pulse, CS deasserted in the middle of a word
//   spi                : SPI pins (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_TX    = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_error,
    spi_slave_if.slave            spi
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int c_MSB   = DATA_WIDTH - 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Synchroniser chains: [0] first flop, [1] synchronised, [2] edge-detect history
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;

    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_miso;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic                  r_word_done;

    logic w_sclk_edge;
    logic w_leading;
    logic w_trailing;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_mosi;
    logic w_word_start;
    logic w_sample;
    logic w_shift;
    logic w_end;
    logic w_last_bit;
    logic [DATA_WIDTH-1:0] w_rx_next;

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi.spi_clk};
            r_cs_sync   <= {r_cs_sync[1:0], spi.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], spi.spi_mosi};
        end
    end

    assign w_sclk_edge = r_sclk_sync[2] ^ r_sclk_sync[1];
    // Leading edge leaves the idle level, trailing edge returns to it
    assign w_leading   = w_sclk_edge & (r_sclk_sync[1] != cpol);
    assign w_trailing  = w_sclk_edge & (r_sclk_sync[1] == cpol);
    assign w_cs_fall   = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_sync[2] & r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_last_bit  = (r_bit_cnt == c_CNT_W'(DATA_WIDTH - 1));
    assign w_rx_next   = DATA_WIDTH'({r_rx_shift, w_mosi});

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_word_start = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_word_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // CS rise takes priority over any SCLK edge in the same cycle
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_end        = 1'b1;
                end else begin
                    w_word_start = r_word_done;
                    w_sample     = cpha ? w_trailing : w_leading;
                    // In CPHA=0 the trailing edge after the last sample of a
                    // word arrives with the counter already wrapped; the next
                    // word's MSB is on the wire by then and must not shift.
                    w_shift      = cpha ? w_leading
                                        : (w_trailing && (r_bit_cnt != '0));
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // TX buffer: can only be loaded while empty, so a consume and a load
    // never collide in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
        end else begin
            if (w_word_start && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (tx_valid && !r_buf_full) begin
                r_buf_full <= 1'b1;
                r_buf_data <= tx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX shift path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift  <= '0;
            r_miso      <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (w_word_start) begin
                if (r_buf_full) begin
                    r_tx_shift <= r_buf_data;
                end else begin
                    r_tx_shift  <= IDLE_TX;
                    tx_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_miso     <= r_tx_shift[c_MSB];
                r_tx_shift <= r_tx_shift << 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX shift path and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            r_word_done <= 1'b0;
            if (w_end) begin
                // Partial word is dropped without an rx_valid
                if (r_bit_cnt != '0) begin
                    frame_error <= 1'b1;
                end
                r_bit_cnt <= '0;
            end else if (w_word_start) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (w_last_bit) begin
                    r_bit_cnt   <= '0;
                    rx_data     <= w_rx_next;
                    rx_valid    <= 1'b1;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: CPHA=0 presents the shift register MSB directly, CPHA=1
    // presents the bit latched on the most recent shift edge.
    // ------------------------------------------------------------------
    assign tx_ready        = ~r_buf_full;
    assign busy            = (r_state == ST_ACTIVE);
    assign spi.spi_miso_oe = busy;
    assign spi.spi_miso    = busy & (cpha ? r_miso : r_tx_shift[c_MSB]);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave. A directed table of
//               frames plus randomized frames checked against a word-level
//               model of the TX buffer, and a mid-word reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int H = 6;   // SCLK half period in clk cycles

    typedef struct {
        bit         cpol;
        bit         cpha;
        int         nwords;   // complete words sent (0..2)
        logic [7:0] m0;
        logic [7:0] m1;
        int         cut;      // bits of a trailing partial word (0 = none)
        bit         pre;      // preload buffer with t0 before CS fall
        logic [7:0] t0;
        bit         load2;    // load t1 once the first word has started
        logic [7:0] t1;
        bit         badld;    // attempt a load while the buffer is full
        logic [7:0] x0;       // expected word seen by the master, word 0
        logic [7:0] x1;       // expected word seen by the master, word 1
        int         xund;     // expected tx_underrun pulses in the frame
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_error;

    spi_slave_if spi ();

    spi_slave #(
        .DATA_WIDTH (8),
        .IDLE_TX    (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpol        (cpol),
        .cpha        (cpha),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun),
        .frame_error (frame_error),
        .spi         (spi)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    string      cur_tag  = "init";
    logic [7:0] last_rx  = 8'h00;

    // Monitor: sole writer of these cumulative counters
    int         rv_cnt   = 0;
    int         und_cnt  = 0;
    int         fe_cnt   = 0;
    int         busy_cnt = 0;
    int         oe_bad   = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rv_cnt++;
            rxq.push_back(rx_data);
        end
        if (tx_underrun === 1'b1) und_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if ((spi.spi_miso_oe !== busy) || ((busy !== 1'b1) && (spi.spi_miso !== 1'b0)))
            oe_bad++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            wait_clk(1);
            n++;
        end
        chk("tx_ready_before_load", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    // Master bit-bang: drives MOSI, samples MISO on the master sample edge
    task automatic xfer_bits(input logic [7:0] m, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                spi.spi_mosi = m[7-i];
                wait_clk(H);
                spi.spi_clk = ~cpol;
                got = {got[6:0], spi.spi_miso};
                wait_clk(H);
                spi.spi_clk = cpol;
            end else begin
                spi.spi_clk  = ~cpol;
                spi.spi_mosi = m[7-i];
                wait_clk(H);
                spi.spi_clk = cpol;
                got = {got[6:0], spi.spi_miso};
                wait_clk(H);
            end
        end
    endtask

    // Word-level model: every word start (CS fall and each completed word)
    // takes the buffered word if one is there, otherwise sends 0xFF and
    // counts an underrun.
    task automatic model(input vec_t v, output logic [7:0] e0, output logic [7:0] e1,
                         output int eund);
        int starts = 1 + v.nwords;
        e0 = 8'hFF;
        e1 = 8'hFF;
        eund = 0;
        for (int k = 0; k < starts; k++) begin
            bit         has = (k == 0) ? v.pre : ((k == 1) && v.load2);
            logic [7:0] w   = has ? ((k == 0) ? v.t0 : v.t1) : 8'hFF;
            if (!has) eund++;
            if (k == 0) e0 = w;
            if (k == 1) e1 = w;
        end
    endtask

    task automatic run_frame(input vec_t v, input logic [7:0] e0, input logic [7:0] e1,
                             input int eund);
        int         rv0, und0, fe0, bz0, bad0, q0;
        logic [7:0] g[2];
        logic [7:0] dummy;
        logic [7:0] r;
        cpol         = v.cpol;
        cpha         = v.cpha;
        spi.spi_clk  = v.cpol;
        spi.spi_mosi = 1'b0;
        wait_clk(4);
        if (v.pre) push(v.t0);
        if (v.badld) begin
            tx_data  = 8'h99;
            tx_valid = 1'b1;
            wait_clk(3);
            tx_valid = 1'b0;
        end
        rv0 = rv_cnt; und0 = und_cnt; fe0 = fe_cnt; bz0 = busy_cnt; bad0 = oe_bad;
        q0  = rxq.size();
        spi.spi_cs_n = 1'b0;
        wait_clk(H);
        chk("busy_in_frame", busy, 1);
        if (v.load2) push(v.t1);
        g[0] = 8'h00;
        g[1] = 8'h00;
        for (int w = 0; w < v.nwords; w++)
            xfer_bits((w == 0) ? v.m0 : v.m1, 8, g[w]);
        if (v.cut > 0) xfer_bits(8'h5A, v.cut, dummy);
        wait_clk(H);
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        wait_clk(12);

        if (v.nwords > 0) last_rx = (v.nwords == 2) ? v.m1 : v.m0;
        chk("rx_valid_count", rv_cnt - rv0, v.nwords);
        for (int w = 0; w < v.nwords; w++) begin
            r = (rxq.size() > q0 + w) ? rxq[q0 + w] : 8'hxx;
            chk($sformatf("rx_word%0d", w), r, (w == 0) ? v.m0 : v.m1);
            chk($sformatf("miso_word%0d", w), g[w], (w == 0) ? e0 : e1);
        end
        chk("underrun_count", und_cnt - und0, eund);
        chk("frame_error_count", fe_cnt - fe0, (v.cut != 0) ? 1 : 0);
        chk("rx_data_held", rx_data, last_rx);
        chk("busy_seen", (busy_cnt - bz0) > 0, 1);
        chk("busy_after", busy, 0);
        chk("tx_ready_after", tx_ready, 1);
        chk("miso_oe_consistency", oe_bad - bad0, 0);
    endtask

    function automatic vec_t mk(bit pol, bit pha, int n, logic [7:0] m0, logic [7:0] m1,
                                int cut, bit pre, logic [7:0] t0, bit l2, logic [7:0] t1,
                                bit bad, logic [7:0] x0, logic [7:0] x1, int xund);
        vec_t v;
        v.cpol = pol;  v.cpha = pha; v.nwords = n; v.m0 = m0; v.m1 = m1;
        v.cut = cut;   v.pre = pre;  v.t0 = t0;    v.load2 = l2; v.t1 = t1;
        v.badld = bad; v.x0 = x0;    v.x1 = x1;    v.xund = xund;
        return v;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_miso", spi.spi_miso, 0);
        chk("rst_miso_oe", spi.spi_miso_oe, 0);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t       v;
        logic [7:0] e0, e1, dummy;
        int         eund;

        // Directed frames: {mode, words, buffer activity} -> {master words, underruns}
        tbl[0] = mk(0, 0, 1, 8'hA5, 8'h00, 0, 1, 8'h3C, 0, 8'h00, 0, 8'h3C, 8'hFF, 1);
        tbl[1] = mk(1, 1, 1, 8'hC3, 8'h00, 0, 1, 8'h5A, 0, 8'h00, 0, 8'h5A, 8'hFF, 1);
        tbl[2] = mk(0, 1, 1, 8'hC3, 8'h00, 0, 1, 8'h5A, 0, 8'h00, 0, 8'h5A, 8'hFF, 1);
        tbl[3] = mk(1, 0, 1, 8'hC3, 8'h00, 0, 1, 8'h5A, 0, 8'h00, 0, 8'h5A, 8'hFF, 1);
        tbl[4] = mk(0, 0, 2, 8'h81, 8'h42, 0, 1, 8'h11, 1, 8'h22, 0, 8'h11, 8'h22, 1);
        tbl[5] = mk(0, 0, 1, 8'h6B, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 8'hFF, 2);
        tbl[6] = mk(0, 0, 0, 8'h00, 8'h00, 4, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 8'hFF, 1);
        tbl[7] = mk(0, 0, 1, 8'h96, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 8'hFF, 2);
        tbl[8] = mk(0, 0, 1, 8'h00, 8'h00, 0, 1, 8'h3C, 0, 8'h00, 1, 8'h3C, 8'hFF, 1);

        rst          = 1'b1;
        cpol         = 1'b0;
        cpha         = 1'b0;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        spi.spi_clk  = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        wait_clk(3);
        cur_tag = "reset";
        check_reset_outputs();
        rst = 1'b0;
        wait_clk(3);
        check_reset_outputs();

        for (int i = 0; i < 9; i++) begin
            cur_tag = $sformatf("dir%0d", i);
            run_frame(tbl[i], tbl[i].x0, tbl[i].x1, tbl[i].xund);
        end

        // Reset in the middle of a word with a word pending in the buffer
        cur_tag = "midrst";
        cpol = 1'b0; cpha = 1'b0; spi.spi_clk = 1'b0;
        wait_clk(4);
        spi.spi_cs_n = 1'b0;
        wait_clk(H);
        push(8'h77);
        xfer_bits(8'hAA, 3, dummy);
        rst = 1'b1;
        wait_clk(2);
        check_reset_outputs();
        spi.spi_cs_n = 1'b1;
        spi.spi_clk  = 1'b0;
        wait_clk(2);
        check_reset_outputs();
        rst = 1'b0;
        wait_clk(5);
        last_rx = 8'h00;
        cur_tag = "post_rst";
        run_frame(mk(0, 0, 1, 8'h0F, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 8'hFF, 2),
                  8'hFF, 8'hFF, 2);

        // Randomized frames against the word-level model
        for (int r = 0; r < 16; r++) begin
            v.cpol   = 1'($urandom_range(0, 1));
            v.cpha   = 1'($urandom_range(0, 1));
            v.nwords = $urandom_range(0, 2);
            v.cut    = (v.nwords == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            v.m0     = 8'($urandom);
            v.m1     = 8'($urandom);
            v.pre    = 1'($urandom_range(0, 1));
            v.t0     = 8'($urandom);
            v.load2  = (v.nwords >= 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.t1     = 8'($urandom);
            v.badld  = 1'b0;
            model(v, e0, e1, eund);
            cur_tag = $sformatf("rnd%0d", r);
            run_frame(v, e0, e1, eund);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
